// File: rtl/if_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// One outstanding imem request, a 1-entry response buffer for stalls, and redirect flush.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode
);

    // state | meaning
    // REQ   | request for pc presented to imem, waiting for ready
    // WAIT  | request accepted, waiting for the response
    // HOLD  | response parked in buffer until IF/ID frees up
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        drop, drop_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic        id_valid_nxt;
    logic [31:0] id_pc_nxt;
    logic [31:0] id_instr_nxt;
    logic [6:0]  id_opcode_nxt;

    logic        slot_free;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        unused_bits;

    assign slot_free       = !stall || !id_valid;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign pc_plus4        = pc + 32'd4;
    assign unused_bits     = ^redirect_pc[1:0];

    assign imem_req_valid = (state == ST_REQ) && !rst;
    assign imem_req_addr  = pc;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_nxt      = drop;
        buf_instr_nxt = buf_instr;
        buf_pc_nxt    = buf_pc;
        id_valid_nxt  = stall && id_valid;
        id_pc_nxt     = id_pc;
        id_instr_nxt  = id_instr;
        id_opcode_nxt = id_opcode;

        case (state)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_target;
                    // The old-address request still goes out; its response must be thrown away.
                    if (imem_req_ready) begin
                        state_nxt = ST_WAIT;
                        drop_nxt  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_target;
                    if (imem_rsp_valid) begin
                        state_nxt = ST_REQ;
                        drop_nxt  = 1'b0;
                    end else begin
                        drop_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_nxt  = 1'b0;
                        state_nxt = ST_REQ;
                    end else if (slot_free) begin
                        id_valid_nxt  = 1'b1;
                        id_pc_nxt     = pc;
                        id_instr_nxt  = imem_rsp_data;
                        id_opcode_nxt = imem_rsp_data[6:0];
                        pc_nxt        = pc_plus4;
                        state_nxt     = ST_REQ;
                    end else begin
                        buf_instr_nxt = imem_rsp_data;
                        buf_pc_nxt    = pc;
                        pc_nxt        = pc_plus4;
                        state_nxt     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_target;
                    state_nxt = ST_REQ;
                end else if (slot_free) begin
                    id_valid_nxt  = 1'b1;
                    id_pc_nxt     = buf_pc;
                    id_instr_nxt  = buf_instr;
                    id_opcode_nxt = buf_instr[6:0];
                    state_nxt     = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase

        // Flush wins over any load or stall-hold decided above.
        if (redirect_valid) begin
            id_valid_nxt  = 1'b0;
            id_instr_nxt  = NOP_INSTR;
            id_opcode_nxt = NOP_INSTR[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_REQ;
            pc        <= RESET_PC_ALIGNED;
            drop      <= 1'b0;
            buf_instr <= 32'd0;
            buf_pc    <= 32'd0;
            id_valid  <= 1'b0;
            id_pc     <= 32'd0;
            id_instr  <= NOP_INSTR;
            id_opcode <= NOP_INSTR[6:0];
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            drop      <= drop_nxt;
            buf_instr <= buf_instr_nxt;
            buf_pc    <= buf_pc_nxt;
            id_valid  <= id_valid_nxt;
            id_pc     <= id_pc_nxt;
            id_instr  <= id_instr_nxt;
            id_opcode <= id_opcode_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: transaction-level reference model checked every cycle,
// plus literal expectations at key points and a second instance for PC wrap from reset.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_stall = 1'b0;
    logic        w_redir = 1'b0;
    logic [31:0] w_redir_pc = 32'd0;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_instr;
    logic [6:0]  w_id_opcode;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int acc0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall(w_stall),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_instr(w_id_instr), .id_opcode(w_id_opcode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch pointer, at most one request in flight (possibly stale),
    // an optional parked instruction, and the IF/ID contents.
    logic        m_live = 1'b0;
    logic [31:0] m_pc;
    logic        m_inflight, m_stale, m_has_buf;
    logic [31:0] m_buf_instr, m_buf_pc;
    logic        m_idv;
    logic [31:0] m_idpc, m_idinstr;
    logic        fire, got, free;

    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) n_acc++;
        if (rst) begin
            m_live = 1'b1;
            m_pc = 32'd0; m_inflight = 1'b0; m_stale = 1'b0; m_has_buf = 1'b0;
            m_buf_instr = 32'd0; m_buf_pc = 32'd0;
            m_idv = 1'b0; m_idpc = 32'd0; m_idinstr = NOP;
        end else if (m_live) begin
            fire = !m_inflight && !m_has_buf && imem_req_ready;
            got  = m_inflight && imem_rsp_valid;
            free = !stall || !m_idv;
            if (redirect_valid) begin
                m_idv = 1'b0;
                m_idinstr = NOP;
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_has_buf = 1'b0;
                if (fire) begin
                    m_inflight = 1'b1; m_stale = 1'b1;
                end else if (got) begin
                    m_inflight = 1'b0; m_stale = 1'b0;
                end else if (m_inflight) begin
                    m_stale = 1'b1;
                end
            end else begin
                if (!stall) m_idv = 1'b0;
                if (m_has_buf) begin
                    if (free) begin
                        m_idv = 1'b1; m_idpc = m_buf_pc; m_idinstr = m_buf_instr;
                        m_has_buf = 1'b0;
                    end
                end else if (got) begin
                    m_inflight = 1'b0;
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        if (free) begin
                            m_idv = 1'b1; m_idpc = m_pc; m_idinstr = imem_rsp_data;
                        end else begin
                            m_has_buf = 1'b1; m_buf_pc = m_pc; m_buf_instr = imem_rsp_data;
                        end
                        m_pc = m_pc + 32'd4;
                    end
                end else if (fire) begin
                    m_inflight = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_req_valid", {31'd0, imem_req_valid}, {31'd0, !rst && !m_inflight && !m_has_buf});
            check("m_req_addr", imem_req_addr, m_pc);
            check("m_addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
            check("m_id_valid", {31'd0, id_valid}, {31'd0, m_idv});
            check("m_id_pc", id_pc, m_idpc);
            check("m_id_instr", id_instr, m_idinstr);
            check("m_id_opcode", {25'd0, id_opcode}, {25'd0, m_idinstr[6:0]});
        end
    end

    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic st, input logic rdv, input logic [31:0] rpc);
        @(posedge clk);
        #2;
        rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        stall = st; redirect_valid = rdv; redirect_pc = rpc;
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_opcode", {25'd0, id_opcode}, 32'h13);

        // reset then two-instruction stream
        step(0, 1, 0, 0, 0, 0, 0);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_addr", imem_req_addr, 32'h0);
        check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
        step(0, 1, 1, 32'h0050_0093, 0, 0, 0);
        check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("s1_id_valid", {31'd0, id_valid}, 32'd1);
        check("s1_id_pc", id_pc, 32'h0);
        check("s1_id_opcode", {25'd0, id_opcode}, 32'h13);
        check("s1_addr", imem_req_addr, 32'h4);
        check("wrap_second_addr", w_req_addr, 32'h0);
        check("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
        step(0, 1, 1, 32'h00A0_0113, 0, 0, 0);

        // backpressure: ready low for 3 cycles
        step(0, 0, 0, 0, 0, 0, 0);
        acc0 = n_acc;
        check("s2_id_pc", id_pc, 32'h4);
        check("s2_id_instr", id_instr, 32'h00A0_0113);
        check("bp_addr0", imem_req_addr, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0);
        check("bp_valid1", {31'd0, imem_req_valid}, 32'd1);
        check("bp_addr1", imem_req_addr, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0);
        check("bp_addr2", imem_req_addr, 32'h8);
        step(0, 1, 0, 0, 0, 0, 0);
        check("bp_addr3", imem_req_addr, 32'h8);
        step(0, 1, 1, 32'h00C0_0193, 0, 0, 0);
        check("bp_one_accept", n_acc - acc0, 32'd1);

        // stall into HOLD
        step(0, 1, 0, 0, 1, 0, 0);
        check("st_id_pc", id_pc, 32'h8);
        step(0, 1, 1, 32'h0000_A023, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("hold_id_pc", id_pc, 32'h8);
        check("hold_id_instr", id_instr, 32'h00C0_0193);
        check("hold_id_valid", {31'd0, id_valid}, 32'd1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("hold_no_req2", {31'd0, imem_req_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("unhold_instr", id_instr, 32'h0000_A023);
        check("unhold_opcode", {25'd0, id_opcode}, 32'h23);
        check("unhold_pc", id_pc, 32'hC);
        check("unhold_addr", imem_req_addr, 32'h10);

        // redirect while waiting, late response dropped
        step(0, 1, 0, 0, 0, 1, 32'h0000_0103);
        step(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check("rw_flush_valid", {31'd0, id_valid}, 32'd0);
        check("rw_flush_instr", id_instr, NOP);
        check("rw_no_req", {31'd0, imem_req_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("rw_addr", imem_req_addr, 32'h100);
        check("rw_id_valid", {31'd0, id_valid}, 32'd0);
        step(0, 1, 1, 32'h0640_0393, 0, 0, 0);
        check("rw_id_valid2", {31'd0, id_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("rw_load_pc", id_pc, 32'h100);
        check("rw_load_instr", id_instr, 32'h0640_0393);

        // redirect + stall + response in WAIT
        step(0, 1, 1, 32'h1111_1111, 1, 1, 32'h200);
        step(0, 1, 0, 0, 0, 1, 32'h300);
        check("sim_flush_instr", id_instr, NOP);
        check("sim_addr", imem_req_addr, 32'h200);
        check("sim_req_valid", {31'd0, imem_req_valid}, 32'd1);
        // redirect in REQ with ready: old request accepted and dropped
        step(0, 1, 1, 32'h2222_2222, 0, 0, 0);
        check("rr_addr", imem_req_addr, 32'h300);
        check("rr_no_req", {31'd0, imem_req_valid}, 32'd0);
        // redirect in REQ without ready, unaligned target near wrap
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
        check("rn_addr_old", imem_req_addr, 32'h300);
        step(0, 1, 0, 0, 0, 0, 0);
        check("rn_addr_new", imem_req_addr, 32'hFFFF_FFFC);
        step(0, 1, 1, 32'h0020_8033, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        check("wrap_id_pc2", id_pc, 32'hFFFF_FFFC);
        check("wrap_addr0", imem_req_addr, 32'h0);

        // redirect from HOLD discards buffer
        step(0, 1, 1, 32'h0031_0233, 1, 0, 0);
        step(0, 1, 0, 0, 1, 1, 32'h40);
        check("rh_no_req", {31'd0, imem_req_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("rh_flush", {31'd0, id_valid}, 32'd0);
        check("rh_addr", imem_req_addr, 32'h40);

        // reset during WAIT
        step(1, 1, 0, 0, 0, 0, 0);
        check("rst_mid_valid", {31'd0, imem_req_valid}, 32'd0);
        step(0, 0, 1, 32'h3333_3333, 0, 0, 0);
        check("rst_mid_addr", imem_req_addr, 32'h0);
        check("rst_mid_req", {31'd0, imem_req_valid}, 32'd1);
        check("rst_mid_idv", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("rsp_ignored_req", {31'd0, imem_req_valid}, 32'd1);
        check("rsp_ignored_idv", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the RV32I 5-stage pipeline.
- Drives the PC, issues word requests to instruction memory with a valid/ready handshake, and captures responses.
- Presents the fetched instruction, its PC and its opcode to the ID stage; the opcode feeds the opcode type decoder directly.
- Handles ID-stage stalls and EX-stage redirects (taken branch/JAL/JALR) with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0 loaded into IF/ID on reset or flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response data valid; only one request is ever outstanding.
- imem_rsp_data  in  32  instruction word.
- stall  in  1  ID cannot consume IF/ID this cycle.
- redirect_valid  in  1  EX redirect / pipeline flush.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- id_valid  out  1  IF/ID holds a valid instruction.
- id_pc  out  32  PC of id_instr.
- id_instr  out  32  fetched instruction.
- id_opcode  out  7  registered copy of id_instr[6:0].

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-request): pc=RESET_PC, state=REQ, drop=0, id_valid=0, id_pc=0, id_instr=NOP_INSTR, id_opcode=7'h13, buffer cleared.
- imem_req_valid is combinational from state: 1 only in REQ, and 0 while rst=1.
- imem_req_addr = pc.
- The first request is presented in the first cycle after rst deasserts.
- State REQ:
  - req_valid=1. On req_ready, go to WAIT.
  - pc is held until the response is accepted. The address must not change while valid=1 && !ready, except on a redirect.
- State WAIT:
  - Waits for rsp_valid.
  - On rsp_valid && drop: discard the data, clear drop, go to REQ.
  - On rsp_valid && slot_free: load IF/ID (id_valid=1, id_pc=pc, id_instr=data, id_opcode=data[6:0]), pc=pc+4, go to REQ.
  - On rsp_valid && !slot_free: store data in the 1-entry buffer, pc=pc+4, go to HOLD.
- State HOLD:
  - No requests are issued.
  - When slot_free, move the buffer into IF/ID (its PC is the old pc, kept alongside the buffer), then go to REQ.
- slot_free = !stall || !id_valid.
- IF/ID when nothing loads: id_valid holds if stall=1, else clears to 0. id_instr, id_pc and id_opcode hold.
- Minimum latency, no stalls, ready=1, response one cycle after acceptance:
  - Request cycle N, response N+1, id_valid=1 at N+2.
  - Throughput is 1 instruction per 2 cycles.
- Redirect (priority over stall and over normal load):
  - IF/ID flushes in all cases: id_valid=0, id_instr=NOP_INSTR, id_opcode=7'h13.
  - pc = {redirect_pc[31:2],2'b00}.
  - REQ with req_ready in the same cycle: the old-address request is accepted; go to WAIT with drop=1.
  - REQ without req_ready: stay in REQ. The next cycle presents the new address.
  - WAIT without rsp_valid: drop=1, stay in WAIT.
  - WAIT with rsp_valid in the same cycle: discard the data, go to REQ.
  - HOLD: discard the buffer, go to REQ.
  - A redirect while drop=1 keeps drop=1 and updates pc.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- imem_rsp_valid outside WAIT is ignored.

Test Plan:
- Reset and stream: rst high 2 cycles, ready=1, memory returns 0x00500093 at 0x0 and 0x00A00113 at 0x4 one cycle later. Required: addr 0x0 then 0x4; id_pc 0x0 / id_opcode 0x13 / id_valid=1, then id_pc 0x4.
- Handshake backpressure: ready=0 for 3 cycles. Required: req_valid stays 1 and addr stays 0x8 throughout; exactly one acceptance.
- Stall/HOLD: stall=1 with id_valid=1 when response 0x0000A023 arrives. Required: state HOLD, no new request, IF/ID unchanged. stall=0 → id_instr=0x0000A023, id_opcode=0x23, next request to pc+4.
- Redirect in WAIT: redirect to 0x0000_0103 before the response. Required: IF/ID flushed to NOP, the late response discarded, next request addr 0x100, id_valid=0 until 0x100 returns.
- Simultaneous redirect+stall+rsp_valid in WAIT: redirect wins. Required: flush, data discarded, next addr = target.
- Wrap and reset mid-request: RESET_PC=0xFFFF_FFFC. Required: second request at 0x0. Asserting rst during WAIT returns to REQ at RESET_PC with id_valid=0.
